fetch_queue: RTL

- Instruction-fetch front end between the instruction memory and the decode stage of dsd_processor.
- Owns the byte-addressed program counter and drives the imem address.
- Captures returned 16-bit instruction words into a small prefetch FIFO.
- Presents {inst, inst_pc} to decode over a valid/ready handshake; supports branch/jump redirect with flush.

---
 rtl/dsd_pkg.sv | 19 +
 rtl/fetch_fifo.sv | 56 +++++
 rtl/fetch_queue.sv | 83 ++++++++
 3 files changed

// File: rtl/dsd_pkg.sv
// Shared widths, defaults and the fetch FIFO entry type for the dsd_processor front end.
package dsd_pkg;

    localparam int          ADDR_W       = 16;
    localparam int          INST_W       = 16;
    localparam logic [15:0] PC_STEP      = 16'd2;
    localparam logic [15:0] NOP_INST_DEF = 16'h0000;

    typedef struct packed {
        logic [INST_W-1:0] inst;
        logic [ADDR_W-1:0] pc;
    } fetch_entry_t;

    // Instructions are halfword aligned, so bit 0 of any fetch address is dropped.
    function automatic logic [ADDR_W-1:0] align_pc(input logic [ADDR_W-1:0] addr);
        return addr & 16'hFFFE;
    endfunction

endpackage

// File: rtl/fetch_fifo.sv
// DEPTH-entry prefetch FIFO of fetch entries; flush overrides push and pop.
module fetch_fifo
    import dsd_pkg::*;
#(
    parameter int DEPTH = 2
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         push,
    input  fetch_entry_t                 push_entry,
    input  logic                         pop,
    input  logic                         flush,
    output fetch_entry_t                 head,
    output logic [$clog2(DEPTH+1)-1:0]   occupancy
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int OCC_W = $clog2(DEPTH+1);

    fetch_entry_t     mem_r [DEPTH];
    logic [PTR_W-1:0] wr_ptr_r;
    logic [PTR_W-1:0] rd_ptr_r;
    logic [OCC_W-1:0] count_r;

    // Storage, pointers and entry count; DEPTH is a power of two so pointers wrap naturally.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_r[i] <= '0;
            end
            wr_ptr_r <= '0;
            rd_ptr_r <= '0;
            count_r  <= '0;
        end else if (flush) begin
            wr_ptr_r <= '0;
            rd_ptr_r <= '0;
            count_r  <= '0;
        end else begin
            if (push) begin
                mem_r[wr_ptr_r] <= push_entry;
                wr_ptr_r        <= wr_ptr_r + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr_r <= rd_ptr_r + PTR_W'(1);
            end
            count_r <= count_r + OCC_W'(push) - OCC_W'(pop);
        end
    end

    // Head and count come straight from registers.
    always_comb begin
        head      = mem_r[rd_ptr_r];
        occupancy = count_r;
    end

endmodule

// File: rtl/fetch_queue.sv
// Instruction fetch front end: owns the pc, drives imem, queues words for decode.
module fetch_queue
    import dsd_pkg::*;
#(
    parameter logic [15:0] RESET_PC = 16'h0000,
    parameter int          DEPTH    = 2,
    parameter logic [15:0] NOP_INST = NOP_INST_DEF
) (
    input  logic                         clk,
    input  logic                         resetn,
    input  logic                         fetch_en,
    output logic [15:0]                  imem_addr,
    input  logic [15:0]                  imem_data,
    input  logic                         redirect_valid,
    input  logic [15:0]                  redirect_pc,
    output logic                         inst_valid,
    output logic [15:0]                  inst,
    output logic [15:0]                  inst_pc,
    input  logic                         inst_ready,
    output logic [$clog2(DEPTH+1)-1:0]   occupancy
);

    localparam int               OCC_W  = $clog2(DEPTH+1);
    localparam logic [OCC_W-1:0] FULL_C = OCC_W'(DEPTH);

    logic [15:0]      pc_r;
    logic             head_valid_s;
    logic             pop_s;
    logic             fire_s;
    fetch_entry_t     push_entry_s;
    fetch_entry_t     head_s;
    logic [OCC_W-1:0] occ_s;

    // Fetch is allowed when a slot is free now or is being freed by this cycle's pop.
    always_comb begin
        head_valid_s      = (occ_s != '0);
        pop_s             = head_valid_s & inst_ready;
        fire_s            = fetch_en & ~redirect_valid & ((occ_s < FULL_C) | pop_s);
        push_entry_s.inst = imem_data;
        push_entry_s.pc   = pc_r;
    end

    // Program counter: redirect beats sequential advance; 16-bit wrap is intended.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            pc_r <= align_pc(RESET_PC);
        end else if (redirect_valid) begin
            pc_r <= align_pc(redirect_pc);
        end else if (fire_s) begin
            pc_r <= pc_r + PC_STEP;
        end else begin
            pc_r <= pc_r;
        end
    end

    fetch_fifo #(
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk        (clk),
        .rst_n      (resetn),
        .push       (fire_s),
        .push_entry (push_entry_s),
        .pop        (pop_s),
        .flush      (redirect_valid),
        .head       (head_s),
        .occupancy  (occ_s)
    );

    // Decode-facing outputs; an empty queue presents a NOP at address zero.
    always_comb begin
        imem_addr  = pc_r;
        inst_valid = head_valid_s;
        occupancy  = occ_s;
        if (head_valid_s) begin
            inst    = head_s.inst;
            inst_pc = head_s.pc;
        end else begin
            inst    = NOP_INST;
            inst_pc = 16'h0000;
        end
    end

endmodule
